// File: rtl/regfile_write_arbiter_if.sv
// One writeback requester channel: valid/ready handshake carrying a destination
// register and its data.
interface regfile_write_arbiter_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int REG_WIDTH  = 32
);
  logic                  valid;
  logic                  ready;
  logic [ADDR_WIDTH-1:0] addr;
  logic [REG_WIDTH-1:0]  data;

  modport master (output valid, addr, data, input ready);
  modport slave  (input valid, addr, data, output ready);
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin share of the register-file write port between EX writeback and MEM
// load return, with a registered write stage, pending-write scoreboard and conflict counter.
module regfile_write_arbiter #(
  parameter int REG_WIDTH  = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  regfile_write_arbiter_if.slave       ex,
  regfile_write_arbiter_if.slave       mem,
  input  logic                         issue_valid,
  input  logic [ADDR_WIDTH-1:0]        issue_addr,
  output logic                         wrEna,
  output logic [ADDR_WIDTH-1:0]        wrAddr,
  output logic [REG_WIDTH-1:0]         wrData,
  output logic [(1<<ADDR_WIDTH)-1:0]   pending,
  output logic [CNT_WIDTH-1:0]         conflicts
);
  localparam int NUM_REGS = 1 << ADDR_WIDTH;

  typedef enum logic {GR_EX = 1'b0, GR_MEM = 1'b1} grant_e;

  grant_e                last_grant, last_grant_nxt;
  logic                  gnt_ex, gnt_mem, xfer, both, wr_real;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [REG_WIDTH-1:0]  win_data;
  logic [NUM_REGS-1:0]   pending_nxt;

  // Ready is held low while reset is asserted so nothing transfers into a dead write stage.
  always_comb begin
    both           = ex.valid && mem.valid;
    gnt_ex         = rst && ex.valid  && (!mem.valid || last_grant == GR_MEM);
    gnt_mem        = rst && mem.valid && (!ex.valid  || last_grant == GR_EX);
    xfer           = gnt_ex || gnt_mem;
    win_addr       = gnt_ex ? ex.addr : mem.addr;
    win_data       = gnt_ex ? ex.data : mem.data;
    wr_real        = xfer && (win_addr != '0);
    last_grant_nxt = last_grant;
    if (gnt_ex)       last_grant_nxt = GR_EX;
    else if (gnt_mem) last_grant_nxt = GR_MEM;
  end

  assign ex.ready  = gnt_ex;
  assign mem.ready = gnt_mem;

  // Clear is applied before set so a fresh issue to the register being written wins.
  always_comb begin
    pending_nxt = pending;
    if (wrEna) pending_nxt[wrAddr] = 1'b0;
    if (issue_valid && issue_addr != '0) pending_nxt[issue_addr] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= GR_MEM;
      wrEna      <= 1'b0;
      wrAddr     <= '0;
      wrData     <= '0;
      pending    <= '0;
      conflicts  <= '0;
    end else begin
      last_grant <= last_grant_nxt;
      wrEna      <= wr_real;
      // An x0 transfer is swallowed: the port keeps its previous address/data.
      if (wr_real) begin
        wrAddr <= win_addr;
        wrData <= win_data;
      end
      pending <= pending_nxt;
      if (both && conflicts != '1) conflicts <= conflicts + CNT_WIDTH'(1);
    end
  end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized and directed bench for regfile_write_arbiter, checked every cycle
// against a behavioural model of the write port, scoreboard and counter.
module tb_regfile_write_arbiter;
  localparam int AW = 5;
  localparam int RW = 32;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              issue_valid;
  logic [AW-1:0]     issue_addr;
  logic              wrEna;
  logic [AW-1:0]     wrAddr;
  logic [RW-1:0]     wrData;
  logic [(1<<AW)-1:0] pending;
  logic [CW-1:0]     conflicts;

  regfile_write_arbiter_if #(.ADDR_WIDTH(AW), .REG_WIDTH(RW)) ex_if ();
  regfile_write_arbiter_if #(.ADDR_WIDTH(AW), .REG_WIDTH(RW)) mem_if ();

  regfile_write_arbiter #(.REG_WIDTH(RW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .ex(ex_if.slave), .mem(mem_if.slave),
    .issue_valid(issue_valid), .issue_addr(issue_addr),
    .wrEna(wrEna), .wrAddr(wrAddr), .wrData(wrData),
    .pending(pending), .conflicts(conflicts)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: who went last, what the write port shows, which registers are owed.
  bit          m_last_ex;
  bit          m_wen;
  int          m_waddr;
  int          m_wdata;
  bit [31:0]   m_pend;
  int          m_conf;

  function automatic bit want_ex();
    return rst && ex_if.valid && (!mem_if.valid || !m_last_ex);
  endfunction
  function automatic bit want_mem();
    return rst && mem_if.valid && (!ex_if.valid || m_last_ex);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_last_ex <= 1'b0; m_wen <= 1'b0; m_waddr <= 0; m_wdata <= 0;
      m_pend <= '0; m_conf <= 0;
    end else begin
      automatic bit        ge = want_ex();
      automatic bit        gm = want_mem();
      automatic int        a  = ge ? int'(ex_if.addr) : int'(mem_if.addr);
      automatic int        d  = ge ? int'(ex_if.data) : int'(mem_if.data);
      automatic bit [31:0] p  = m_pend;
      if (ge) m_last_ex <= 1'b1;
      else if (gm) m_last_ex <= 1'b0;
      m_wen <= (ge || gm) && a != 0;
      if ((ge || gm) && a != 0) begin m_waddr <= a; m_wdata <= d; end
      if (m_wen) p[m_waddr] = 1'b0;
      if (issue_valid && issue_addr != 0) p[issue_addr] = 1'b1;
      m_pend <= p;
      if (ex_if.valid && mem_if.valid && m_conf < CMAX) m_conf <= m_conf + 1;
    end
  end

  always @(negedge clk) begin
    check("ex_ready",  64'(ex_if.ready),  64'(want_ex()));
    check("mem_ready", 64'(mem_if.ready), 64'(want_mem()));
    check("wrEna",     64'(wrEna),        64'(m_wen));
    check("wrAddr",    64'(wrAddr),       64'(m_waddr));
    check("wrData",    64'(wrData),       64'(unsigned'(m_wdata)));
    check("pending",   64'(pending),      64'(m_pend));
    check("conflicts", 64'(conflicts),    64'(m_conf));
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input bit ev, input int ea, input int ed,
                         input bit mv, input int ma, input int md);
    ex_if.valid  = ev; ex_if.addr  = AW'(ea); ex_if.data  = RW'(ed);
    mem_if.valid = mv; mem_if.addr = AW'(ma); mem_if.data = RW'(md);
  endtask

  task automatic do_reset(input bit all_active);
    rst = 1'b0;
    if (all_active) begin
      set_req(1, 9, 32'h1234, 1, 10, 32'h5678);
      issue_valid = 1'b1; issue_addr = 5'd3;
    end
    repeat (2) @(negedge clk);
    check("rst_wrEna",     64'(wrEna),        64'(0));
    check("rst_pending",   64'(pending),      64'(0));
    check("rst_conflicts", 64'(conflicts),    64'(0));
    check("rst_ex_ready",  64'(ex_if.ready),  64'(0));
    check("rst_mem_ready", 64'(mem_if.ready), 64'(0));
    tick();
    rst = 1'b1;
    if (all_active) begin
      set_req(0, 0, 0, 0, 0, 0);
      issue_valid = 1'b0; issue_addr = '0;
    end
  endtask

  // Random requester: holds valid/addr/data until the handshake completes.
  task automatic step_rand();
    bit ex_acc, mem_acc;
    @(negedge clk);
    ex_acc  = ex_if.valid && ex_if.ready;
    mem_acc = mem_if.valid && mem_if.ready;
    tick();
    if (!ex_if.valid || ex_acc) begin
      ex_if.valid = ($urandom_range(0, 99) < 60);
      ex_if.addr  = AW'($urandom_range(0, 7));
      ex_if.data  = $urandom;
    end
    if (!mem_if.valid || mem_acc) begin
      mem_if.valid = ($urandom_range(0, 99) < 60);
      mem_if.addr  = AW'($urandom_range(0, 7));
      mem_if.data  = $urandom;
    end
    issue_valid = ($urandom_range(0, 99) < 40);
    issue_addr  = AW'($urandom_range(0, 7));
  endtask

  initial begin
    issue_valid = 1'b0; issue_addr = '0;
    set_req(0, 0, 0, 0, 0, 0);
    do_reset(1);

    // Single EX request
    set_req(1, 5, 32'hDEADBEEF, 0, 0, 0);
    @(negedge clk); check("single_ex_ready", 64'(ex_if.ready), 64'(1));
    tick(); set_req(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("single_wrEna", 64'(wrEna), 64'(1));
    check("single_wrAddr", 64'(wrAddr), 64'(5));
    check("single_wrData", 64'(wrData), 64'h0DEADBEEF);

    // Tie after reset: EX first, then MEM
    do_reset(0);
    set_req(1, 3, 32'h11, 1, 4, 32'h22);
    @(negedge clk);
    check("tie_ex_first", 64'(ex_if.ready), 64'(1));
    check("tie_mem_wait", 64'(mem_if.ready), 64'(0));
    tick(); ex_if.valid = 1'b0;
    @(negedge clk);
    check("tie_mem_second", 64'(mem_if.ready), 64'(1));
    check("tie_wr1_addr", 64'(wrAddr), 64'(3));
    check("tie_wr1_data", 64'(wrData), 64'h11);
    tick(); mem_if.valid = 1'b0;
    @(negedge clk);
    check("tie_wr2_en", 64'(wrEna), 64'(1));
    check("tie_wr2_addr", 64'(wrAddr), 64'(4));
    check("tie_wr2_data", 64'(wrData), 64'h22);
    check("tie_conflicts", 64'(conflicts), 64'(1));
    check("model_tie_conf", 64'(m_conf), 64'(1));

    // Scoreboard: issue r7 alongside a write to r7, re-issue while it lands
    tick(); issue_valid = 1'b1; issue_addr = 5'd7; set_req(1, 7, 32'h77, 0, 0, 0);
    tick(); set_req(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("sb_set", 64'(pending[7]), 64'(1));
    check("sb_wr7_on", 64'(wrEna && wrAddr == 5'd7), 64'(1));
    tick(); issue_valid = 1'b0;
    @(negedge clk); check("sb_set_wins", 64'(pending[7]), 64'(1));
    tick(); set_req(1, 7, 32'h78, 0, 0, 0);
    tick(); set_req(0, 0, 0, 0, 0, 0);
    @(negedge clk); check("sb_still_owed", 64'(pending[7]), 64'(1));
    tick();
    @(negedge clk); check("sb_cleared", 64'(pending), 64'(0));
    issue_valid = 1'b1; issue_addr = 5'd0;
    tick(); issue_valid = 1'b0;
    @(negedge clk); check("sb_r0_ignored", 64'(pending), 64'(0));

    // x0 write from MEM
    set_req(0, 0, 0, 1, 0, 32'hFFFFFFFF);
    @(negedge clk); check("x0_mem_ready", 64'(mem_if.ready), 64'(1));
    tick(); set_req(0, 0, 0, 0, 0, 0);
    @(negedge clk); check("x0_no_write", 64'(wrEna), 64'(0));

    // Saturation with strict alternation
    do_reset(0);
    set_req(1, 1, 100, 1, 2, 200);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("sat_ex_ready", 64'(ex_if.ready), 64'(i % 2 == 0));
      check("sat_mem_ready", 64'(mem_if.ready), 64'(i % 2 == 1));
      tick();
      if (i % 2 == 0) ex_if.data = RW'(300 + i);
      else mem_if.data = RW'(400 + i);
    end
    @(negedge clk); check("sat_conflicts", 64'(conflicts), 64'(15));
    tick(); set_req(0, 0, 0, 0, 0, 0);
    tick();
    @(negedge clk);
    check("sat_hold", 64'(conflicts), 64'(15));
    check("model_sat_conf", 64'(m_conf), 64'(15));

    // Random traffic with a reset in the middle
    for (int i = 0; i < 1500; i++) step_rand();
    do_reset(0);
    for (int i = 0; i < 1500; i++) step_rand();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
